multi_code_decoder: RTL
=======================

Name: multi_code_decoder

Overview:
- Receive side of the multi-code path. Accepts a pair of 4-bit coded words (A, B) plus a mode tag, decodes both back to plain binary, flags invalid codes, and compares the decoded values.
- Mode encoding: 00 binary, 01 Gray, 10 Excess-3, 11 BCD.
- Sits between the coded-data link and the binary datapath; valid/ready handshake on both sides.

Parameters:
- GRAY_SERIAL, 1, 1 = Gray decode resolves one bit per cycle (3 extra cycles); 0 = Gray decode in a single cycle like the other modes.
- ERRCNT_W, 8, width of the saturating invalid-code counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  code pair present
- in_ready  out  1  decoder can accept; combinational from state and out_ready
- codeA, codeB  in  4 each  coded words
- mode  in  2  code type of codeA/codeB
- out_valid  out  1  decoded result valid
- out_ready  in  1  downstream accepts result
- binA, binB  out  4 each  decoded binary values
- gt, lt, eq  out  1 each  compare binA vs binB
- err_a, err_b  out  1 each  invalid code on A / B
- err_count  out  ERRCNT_W  saturating count of accepted pairs with err_a or err_b set

Behaviour:
- Reset (rst high at edge): state IDLE, out_valid=0, binA=binB=0, gt=lt=eq=0, err_a=err_b=0, err_count=0. While rst is high, in_ready=0.
- States: IDLE, GRAY, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept: in_valid & in_ready at an edge. codeA, codeB and mode are latched; later input changes are ignored.
- Decode per lane:
  - 00: bin = code, no error.
  - 10: bin = code - 3. err if code<3 or code>12, with bin forced to 0.
  - 11: bin = code. err if code>9, with bin forced to 0.
  - 01: bin[3] = g[3], then bin[i] = bin[i+1] ^ g[i] for i = 2, 1, 0. Never errors.
- Non-Gray modes, or GRAY_SERIAL=0: results registered at the accept edge. Next state DONE, so out_valid is high in the cycle after accept (latency 1).
- Gray with GRAY_SERIAL=1:
  - Accept edge: bin[3] is set and a 2-bit counter loads 2; next state GRAY.
  - Each GRAY edge resolves bit[cnt] and decrements cnt.
  - After the cnt==0 edge, next state DONE. out_valid rises 4 cycles after accept.
- Compare:
  - Registered together with the final bin bits, so flags are valid exactly when out_valid=1.
  - If err_a|err_b: gt=lt=eq=0.
  - Otherwise exactly one of gt/lt/eq is set, by unsigned compare of binA vs binB.
- DONE:
  - out_valid=1 and all outputs held stable while out_ready=0.
  - If out_ready=1 and in_valid=1: the new pair is accepted in the same edge (back-to-back, one result per cycle for non-Gray modes).
  - If out_ready=1 and in_valid=0: go to IDLE with out_valid=0.
- err_count: increments by 1 at the edge where a result with err_a|err_b is first registered, once per pair, not per lane. Saturates at all-ones.
- Reset in GRAY or DONE: transaction discarded, no out_valid pulse, err_count cleared.
- mode/code changes while in GRAY: no effect.

Decomposition:
- Package multi_code_pkg:
  - mode constants MODE_BIN=2'b00, MODE_GRAY=2'b01, MODE_XS3=2'b10, MODE_BCD=2'b11
  - state encoding ST_IDLE, ST_GRAY, ST_DONE
  - XS3_MIN=3, XS3_MAX=12, BCD_MAX=9
- Sub-module code_decode_lane: one 4-bit lane holding its code register, Gray bit-serial logic and error check. Instantiated twice (A, B). Counter and FSM stay in the top level.

Test Plan:
- Gray decode: mode=01, codeA=4'b1101, codeB=4'b0110, GRAY_SERIAL=1, out_ready=1 -> out_valid rises 4 cycles after accept; binA=9, binB=4, gt=1, err_a=err_b=0.
- Excess-3 error: mode=10, codeA=4'hC, codeB=4'h2 -> 1 cycle later binA=9, binB=0, err_b=1, gt=lt=eq=0, err_count=1.
- BCD: mode=11, A=7, B=7 -> eq=1. Then A=4'hA, B=3 -> err_a=1, binA=0, err_count increments by 1. Also preload 255 accepted errors -> err_count stays 8'hFF.
- Backpressure: hold out_ready=0 for 5 cycles after a mode=00 result (A=5, B=9) -> outputs stable (binA=5, binB=9, lt=1), in_ready=0, the next in_valid pair is not consumed until out_ready=1.
- Throughput: mode=00, four consecutive pairs with in_valid=out_ready=1 -> four results on four consecutive cycles, in_ready constantly 1 after the first.
- Reset mid-operation: assert rst for 1 cycle during the 2nd GRAY cycle -> out_valid never rises, next cycle in_ready=1, all outputs 0, err_count=0.

Source files
------------

// File: rtl/multi_code_pkg.sv
// multi_code_pkg: shared mode codes, FSM encoding and single-cycle lane decode helper
package multi_code_pkg;
    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_GRAY = 2'b01;
    localparam logic [1:0] MODE_XS3  = 2'b10;
    localparam logic [1:0] MODE_BCD  = 2'b11;
    localparam logic [3:0] XS3_MIN   = 4'd3;
    localparam logic [3:0] XS3_MAX   = 4'd12;
    localparam logic [3:0] BCD_MAX   = 4'd9;
    typedef enum logic [1:0] {ST_IDLE, ST_GRAY, ST_DONE} state_t;
    typedef struct packed {
        logic       err;
        logic [3:0] bin;
    } dec_t;
    // Full decode of one coded word; invalid codes force bin to zero
    function automatic dec_t decode(input logic [1:0] mode, input logic [3:0] code);
        dec_t d;
        d.err = (mode == MODE_XS3) ? (code < XS3_MIN || code > XS3_MAX) :
                (mode == MODE_BCD) ? (code > BCD_MAX) : 1'b0;
        d.bin = d.err ? 4'd0 :
                (mode == MODE_XS3)  ? code - XS3_MIN :
                (mode == MODE_GRAY) ? code ^ (code >> 1) ^ (code >> 2) ^ (code >> 3) : code;
        return d;
    endfunction
endpackage

// File: rtl/code_decode_lane.sv
// code_decode_lane: one 4-bit lane with latched code, bit-serial Gray resolve and error flag
module code_decode_lane
    import multi_code_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       serial,
    input  logic       step,
    input  logic [1:0] cnt,
    input  logic [1:0] mode,
    input  logic [3:0] code,
    output logic [3:0] bin,
    output logic [3:0] bin_nx,
    output logic       err,
    output logic       err_nx
);
    logic [3:0] g;
    logic [3:0] sh;
    logic [3:0] stepped;
    dec_t       d;
    // Next lane value: full decode, Gray MSB seed, or one resolved Gray bit
    always_comb begin
        d = decode(mode, code);
        sh = bin >> 1;
        stepped = bin;
        stepped[cnt] = sh[cnt] ^ g[cnt];
        bin_nx = load ? (serial ? {code[3], 3'b000} : d.bin) : step ? stepped : bin;
        err_nx = load ? d.err : err;
    end
    // Lane registers; the code is kept for later Gray steps
    always_ff @(posedge clk) begin
        if (rst) begin
            g <= 4'd0;
            bin <= 4'd0;
            err <= 1'b0;
        end else begin
            if (load) g <= code;
            bin <= bin_nx;
            err <= err_nx;
        end
    end
endmodule

// File: rtl/multi_code_decoder.sv
// multi_code_decoder: decodes a pair of coded words, flags bad codes and compares the results
module multi_code_decoder
    import multi_code_pkg::*;
#(
    parameter int GRAY_SERIAL = 1,
    parameter int ERRCNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          codeA,
    input  logic [3:0]          codeB,
    input  logic [1:0]          mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          binA,
    output logic [3:0]          binB,
    output logic                gt,
    output logic                lt,
    output logic                eq,
    output logic                err_a,
    output logic                err_b,
    output logic [ERRCNT_W-1:0] err_count
);
    state_t     state, nstate;
    logic [1:0] cnt;
    logic       accept, serial, step, finish, any_err;
    logic [3:0] a_nx, b_nx;
    logic       ea_nx, eb_nx;
    code_decode_lane u_a (
        .clk(clk), .rst(rst), .load(accept), .serial(serial), .step(step), .cnt(cnt),
        .mode(mode), .code(codeA), .bin(binA), .bin_nx(a_nx), .err(err_a), .err_nx(ea_nx)
    );
    code_decode_lane u_b (
        .clk(clk), .rst(rst), .load(accept), .serial(serial), .step(step), .cnt(cnt),
        .mode(mode), .code(codeB), .bin(binB), .bin_nx(b_nx), .err(err_b), .err_nx(eb_nx)
    );
    // Handshake, result-complete strobe and next state
    always_comb begin
        in_ready = ~rst & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
        accept = in_valid & in_ready;
        serial = (GRAY_SERIAL != 0) & (mode == MODE_GRAY);
        step = (state == ST_GRAY);
        finish = (accept & ~serial) | (step & (cnt == 2'd0));
        any_err = ea_nx | eb_nx;
        out_valid = (state == ST_DONE);
        nstate = accept ? (serial ? ST_GRAY : ST_DONE) :
                 step ? ((cnt == 2'd0) ? ST_DONE : ST_GRAY) :
                 ((state == ST_DONE) & ~out_ready) ? ST_DONE : ST_IDLE;
    end
    // State, Gray bit counter, compare flags and saturating error count
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt <= 2'd0;
            gt <= 1'b0;
            lt <= 1'b0;
            eq <= 1'b0;
            err_count <= '0;
        end else begin
            state <= nstate;
            cnt <= accept ? 2'd2 : step ? cnt - 2'd1 : cnt;
            if (finish) begin
                gt <= ~any_err & (a_nx > b_nx);
                lt <= ~any_err & (a_nx < b_nx);
                eq <= ~any_err & (a_nx == b_nx);
                if (any_err & ~&err_count) err_count <= err_count + ERRCNT_W'(1);
            end
        end
    end
endmodule
